// File: rtl/uart_tx_prog.sv
// UART transmitter (8N1) with a runtime-programmable bit period and a small
// byte FIFO so that queued bytes leave back-to-back with no idle gap.
module uart_tx_prog #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              i_Clock,
  input  logic              rst_i,
  input  logic              i_Tx_DV,
  input  logic [7:0]        i_Tx_Byte,
  input  logic [15:0]       CLKS_PER_BIT,
  output logic              o_Tx_Ready,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Active,
  output logic              o_Tx_Done,
  output logic [ADDR_W:0]   o_Fifo_Count
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

  logic [7:0]        mem_q [FIFO_DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ready_q, ready_d;
  logic [7:0]        shift_q, shift_d;
  logic [15:0]       period_q, period_d;
  logic [15:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              serial_q, serial_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              bit_end;

  always_comb begin
    push       = i_Tx_DV && ready_q;
    fifo_empty = (count_q == '0);
    bit_end    = (clk_cnt_q == period_q - 16'd1);
    pop        = 1'b0;

    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    shift_d   = shift_q;
    period_d  = period_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (!fifo_empty) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          serial_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          clk_cnt_d = 16'd0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            serial_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            active_d = 1'b0;
            state_d  = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame load: shared by IDLE start-up and chained STOP->START.
    if (pop) begin
      shift_d   = mem_q[rd_ptr_q];
      period_d  = (CLKS_PER_BIT == 16'd0) ? 16'd1 : CLKS_PER_BIT;
      clk_cnt_d = 16'd0;
      bit_idx_d = 3'd0;
      serial_d  = 1'b0;
      active_d  = 1'b1;
      state_d   = START;
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != DEPTH_C);
  end

  always_ff @(posedge i_Clock) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      shift_q   <= 8'd0;
      period_q  <= 16'd1;
      clk_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      shift_q   <= shift_d;
      period_q  <= period_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
  end

  assign o_Tx_Ready   = ready_q;
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Count = count_q;

endmodule
